// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;
    localparam int WORD_BYTES = 8;
    localparam int DMEM_WORDS = 128;
    localparam int NUM_PORTS  = 2;

    typedef struct packed {
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        fault;
    } dmem_resp_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port not granted most recently wins.
module rr_arbiter2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    port_e last_grant;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Resetting to the debug port makes the CPU port win the first tie.
    always_ff @(posedge clk) begin
        if (!rstn)
            last_grant <= PORT_DBG;
        else if (|grant)
            last_grant <= grant[1] ? PORT_DBG : PORT_CPU;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU LSU and the debug loader,
// with alignment/range checks and a one-deep response slot per port.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int WORDS  = DMEM_WORDS,
    parameter int FCNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS-1:0][63:0]     req_addr,
    input  logic [NUM_PORTS-1:0][63:0]     req_wdata,
    output logic [NUM_PORTS-1:0]           resp_valid,
    input  logic [NUM_PORTS-1:0]           resp_ready,
    output logic [NUM_PORTS-1:0][63:0]     resp_rdata,
    output logic [NUM_PORTS-1:0]           resp_fault,
    output logic [63:0]                    mem_address,
    output logic [63:0]                    mem_write_data,
    output logic                           mem_write_en,
    output logic                           mem_read_en,
    input  logic [63:0]                    mem_read_data,
    output logic [FCNT_W-1:0]              fault_count
);
    localparam logic [63:0] BYTE_RANGE = 64'(WORDS * WORD_BYTES);

    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] grant;
    logic                 any_grant;
    logic                 sel_port;
    logic                 fault;
    dmem_req_t            sel_req;
    dmem_resp_t           cap;

    // A full slot that drains this cycle frees room for a new accept.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            eligible[p] = rstn & req_valid[p] & (~resp_valid[p] | resp_ready[p]);
    end

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rstn  (rstn),
        .req   (eligible),
        .grant (grant)
    );

    assign req_ready = grant;
    assign any_grant = |grant;
    assign sel_port  = grant[PORT_DBG];

    always_comb begin
        sel_req.write = req_write[sel_port];
        sel_req.addr  = req_addr[sel_port];
        sel_req.wdata = req_wdata[sel_port];
    end

    assign fault = any_grant &
                   ((sel_req.addr[2:0] != 3'b000) | (sel_req.addr >= BYTE_RANGE));

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        if (any_grant && !fault) begin
            mem_address    = sel_req.addr;
            mem_write_data = sel_req.wdata;
            mem_write_en   = sel_req.write;
            mem_read_en    = ~sel_req.write;
        end
    end

    always_comb begin
        cap.fault = fault;
        cap.rdata = (fault || sel_req.write) ? 64'd0 : mem_read_data;
    end

    // Reload takes priority over drain so back-to-back accepts keep the slot full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            resp_valid <= '0;
            resp_fault <= '0;
            resp_rdata <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant[p]) begin
                    resp_valid[p] <= 1'b1;
                    resp_fault[p] <= cap.fault;
                    resp_rdata[p] <= cap.rdata;
                end else if (resp_valid[p] && resp_ready[p]) begin
                    resp_valid[p] <= 1'b0;
                    resp_fault[p] <= 1'b0;
                    resp_rdata[p] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            fault_count <= '0;
        else if (fault && (fault_count != {FCNT_W{1'b1}}))
            fault_count <= fault_count + 1'b1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural memory, reference model and
// per-port response scoreboard.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk;
    logic              rstn;
    logic [1:0]        req_valid, req_ready, req_write;
    logic [1:0][63:0]  req_addr, req_wdata;
    logic [1:0]        resp_valid, resp_ready, resp_fault;
    logic [1:0][63:0]  resp_rdata;
    logic [63:0]       mem_address, mem_write_data, mem_read_data;
    logic              mem_write_en, mem_read_en;
    logic [1:0]        fault_count;

    logic [63:0] mem   [128];
    logic [63:0] model [128];
    dmem_resp_t  exp_q [2][$];
    dmem_resp_t  mon_e;
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.WORDS(128), .FCNT_W(2)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_read_data(mem_read_data), .fault_count(fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[9:3]];
    always @(posedge clk) if (mem_write_en) mem[mem_address[9:3]] <= mem_write_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop on consume, then push the model's answer for each accept.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q[0].delete();
            exp_q[1].delete();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (resp_valid[p] && resp_ready[p]) begin
                    chk("resp_expected", 64'(exp_q[p].size() != 0), 64'd1);
                    if (exp_q[p].size() != 0) begin
                        mon_e = exp_q[p].pop_front();
                        chk("resp_rdata", resp_rdata[p], mon_e.rdata);
                        chk("resp_fault", 64'(resp_fault[p]), 64'(mon_e.fault));
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && req_ready[p]) begin
                    mon_e.fault = (req_addr[p][2:0] != 3'b0) || (req_addr[p] >= 64'd1024);
                    mon_e.rdata = (mon_e.fault || req_write[p]) ? 64'd0 : model[req_addr[p][9:3]];
                    if (!mon_e.fault && req_write[p]) model[req_addr[p][9:3]] = req_wdata[p];
                    exp_q[p].push_back(mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i]   = 64'd0;
            model[i] = 64'd0;
        end
        rstn = 1'b0; resp_ready = 2'b11;
        req_valid = 2'b11; req_write = 2'b00;
        req_addr[0] = 64'h8; req_addr[1] = 64'h10;
        req_wdata[0] = 64'd0; req_wdata[1] = 64'd0;
        repeat (2) nxt();

        // reset: outputs cleared, requests masked
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_mem_en", 64'({mem_write_en, mem_read_en}), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_fault_count", 64'(fault_count), 64'd0);
        nxt();

        // tie after reset: 0, 1, 0 with responses one cycle later
        rstn = 1'b1;
        @(negedge clk); chk("tie_g0", 64'(req_ready), 64'd1); chk("tie_rv0", 64'(resp_valid), 64'd0); nxt();
        @(negedge clk); chk("tie_g1", 64'(req_ready), 64'd2); chk("tie_rv1", 64'(resp_valid), 64'd1); nxt();
        @(negedge clk); chk("tie_g2", 64'(req_ready), 64'd1); chk("tie_rv2", 64'(resp_valid), 64'd2); nxt();
        req_valid = 2'b00;
        @(negedge clk); chk("tie_rv3", 64'(resp_valid), 64'd1); nxt();

        // port 0 store then load
        req_valid = 2'b01; req_write[0] = 1'b1;
        req_addr[0] = 64'h40; req_wdata[0] = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        chk("st_we", 64'(mem_write_en), 64'd1);
        chk("st_addr", mem_address, 64'h40);
        chk("st_wdata", mem_write_data, 64'hDEADBEEF_CAFEF00D);
        nxt();
        req_write[0] = 1'b0;
        @(negedge clk);
        chk("ld_we", 64'(mem_write_en), 64'd0);
        chk("ld_re", 64'(mem_read_en), 64'd1);
        nxt();
        req_valid = 2'b00;
        @(negedge clk);
        chk("ld_rv", 64'(resp_valid), 64'd1);
        chk("ld_rdata", resp_rdata[0], 64'hDEADBEEF_CAFEF00D);
        chk("ld_fault", 64'(resp_fault[0]), 64'd0);
        nxt();

        // misaligned then out-of-range stores on port 1
        req_valid = 2'b10; req_write[1] = 1'b1;
        req_addr[1] = 64'h43; req_wdata[1] = 64'h1234_5678;
        @(negedge clk);
        chk("mis_ready", 64'(req_ready), 64'd2);
        chk("mis_en", 64'({mem_write_en, mem_read_en}), 64'd0);
        chk("mis_fc0", 64'(fault_count), 64'd0);
        nxt();
        req_addr[1] = 64'h400;
        @(negedge clk);
        chk("oor_en", 64'({mem_write_en, mem_read_en}), 64'd0);
        chk("mis_fault", 64'(resp_fault[1]), 64'd1);
        chk("mis_rdata", resp_rdata[1], 64'd0);
        chk("mis_fc1", 64'(fault_count), 64'd1);
        nxt();
        req_valid = 2'b00;
        @(negedge clk);
        chk("oor_fault", 64'(resp_fault[1]), 64'd1);
        chk("oor_rdata", resp_rdata[1], 64'd0);
        chk("oor_fc2", 64'(fault_count), 64'd2);
        nxt();

        // backpressure on port 0 while port 1 keeps flowing
        resp_ready = 2'b10; req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 64'h40;
        @(negedge clk); chk("bp_first", 64'(req_ready), 64'd1); nxt();
        req_valid = 2'b11; req_addr[1] = 64'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'd2);
            chk("bp_hold", 64'(resp_valid[0]), 64'd1);
            nxt();
        end
        resp_ready = 2'b11;
        @(negedge clk); chk("bp_release", 64'(req_ready), 64'd1); nxt();
        req_valid = 2'b00;
        @(negedge clk); nxt();
        @(negedge clk); chk("bp_idle", 64'(resp_valid), 64'd0); nxt();

        // reset in the cycle a port 0 store is valid, port 1 response pending
        resp_ready = 2'b01; req_valid = 2'b10; req_addr[1] = 64'h8;
        @(negedge clk); chk("mr_pre", 64'(req_ready), 64'd2); nxt();
        req_valid = 2'b01; req_write[0] = 1'b1;
        req_addr[0] = 64'h50; req_wdata[0] = 64'hFACE_0000_1111_2222;
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_we", 64'(mem_write_en), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        chk("mr_pending", 64'(resp_valid), 64'd2);
        nxt();
        rstn = 1'b1; req_valid = 2'b00; resp_ready = 2'b11; req_write = 2'b00;
        @(negedge clk);
        chk("mr_rv", 64'(resp_valid), 64'd0);
        chk("mr_fc", 64'(fault_count), 64'd0);
        nxt();
        req_valid = 2'b01;
        @(negedge clk); chk("mr_ld_ready", 64'(req_ready), 64'd1); nxt();
        req_valid = 2'b00;
        @(negedge clk);
        chk("mr_ld_rv", 64'(resp_valid), 64'd1);
        chk("mr_ld_rdata", resp_rdata[0], 64'd0);
        nxt();

        // fault counter saturates at 3 with a 2-bit counter
        req_valid = 2'b10; req_addr[1] = 64'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("sat_step", 64'(fault_count), 64'((i > 3) ? 3 : i));
            nxt();
        end
        req_valid = 2'b00;
        @(negedge clk); chk("sat_a", 64'(fault_count), 64'd3); nxt();
        @(negedge clk); chk("sat_b", 64'(fault_count), 64'd3); nxt();

        chk("q0_drained", 64'(exp_q[0].size()), 64'd0);
        chk("q1_drained", 64'(exp_q[1].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port 64-bit data memory between the CPU load/store unit (port 0) and the debug/program loader (port 1). It grants at most one access per cycle using round-robin priority and checks alignment and range before touching memory. It also returns each port's response through a one-deep registered response slot with backpressure. It sits between the requesters and the memory, and is the only driver of the memory's address, write data and enables.

## Interface

- `WORDS`, 128: memory depth in 64-bit words; the byte range is `WORDS*8`.
- `FCNT_W`, 16: width of the fault counter.
- `clk`  in  1: clock.
- `rstn`  in  1: reset, synchronous, active-low.
- `req_valid[p]`  in  1 each (p = 0, 1): request present.
- `req_ready[p]`  out  1 each: request accepted this cycle when it and `req_valid[p]` are high.
- `req_write[p]`  in  1 each: 1 = store, 0 = load.
- `req_addr[p]`  in  64 each: byte address.
- `req_wdata[p]`  in  64 each: store data.
- `resp_valid[p]`  out  1 each: response slot full.
- `resp_ready[p]`  in  1 each: requester consumes the response.
- `resp_rdata[p]`  out  64 each: load data; 0 for stores and faults.
- `resp_fault[p]`  out  1 each: access rejected.
- `mem_address`  out  64: to the memory.
- `mem_write_data`  out  64: to the memory.
- `mem_write_en`  out  1: to the memory.
- `mem_read_en`  out  1: to the memory.
- `mem_read_data`  in  64: combinational read from the memory.
- `fault_count`  out  `FCNT_W`: saturating count of faulted accepts.

## Operation

- **Eligibility.**
  - Port p is eligible when `req_valid[p]` is high, its response slot is empty or draining this cycle (`resp_valid[p] & resp_ready[p]`), and `rstn` is high.
- **Arbitration.**
  - One eligible port: it is granted.
  - Both eligible: the port not granted most recently wins.
  - The `last_grant` register updates only on a grant.
  - `req_ready[p]` equals grant[p], so it is combinational and at most one bit is high.
- **Fault check** (on the granted request):
  - misaligned: `addr[2:0] != 0`;
  - out of range: `addr >= WORDS*8`;
  - either condition sets `fault`.
- **Memory drive.**
  - Granted and not faulted: `mem_read_en = ~write` and `mem_write_en = write`.
  - `mem_address` and `mem_write_data` are muxed from the granted port.
  - Otherwise both enables are 0, and address and data are 0.
  - A faulted request never asserts either enable.
- **Response capture.** At the posedge of the grant cycle, the granted port's slot loads:
  - `resp_valid = 1`;
  - `resp_fault = fault`;
  - `resp_rdata = mem_read_data` for a non-faulted load, else 0.
- **Slot clear.** A slot clears on `resp_valid & resp_ready` unless it is reloaded in the same cycle; reload wins.
- **Fault counter.** `fault_count` increments on each faulted grant and saturates at all-ones.

## Timing

- **Reset values** (when `rstn` is low at a posedge):
  - `resp_valid`, `resp_fault` and `resp_rdata` are 0 for both ports;
  - `fault_count` is 0;
  - `last_grant` is 1, so port 0 wins the first tie.
- **During reset:** `req_ready` and all memory enables are held 0 combinationally.
- **Mid-operation reset:** a pending response is discarded and no memory write occurs in that cycle.
- **Latency and throughput:**
  - request accepted in cycle N, response valid in cycle N+1;
  - a store commits to memory at the end of cycle N;
  - a load in N+1 to the same address returns the new data;
  - throughput is one access per cycle in total, across both ports.
- **Backpressure:** a held (undrained) response blocks further grants to that port only; the other port continues.
- **Tie-breaking:** with continuous contention and both slots draining, grants alternate 0, 1, 0, 1.
- **Simultaneous drain and accept:** the slot stays valid, carrying the new data.

## Structure

- **Package `dmem_pkg`:**
  - `WORD_BYTES = 8`;
  - `DMEM_WORDS = 128`;
  - a `dmem_req_t` struct (write, addr, wdata);
  - a `dmem_resp_t` struct (rdata, fault);
  - a port index enum `PORT_CPU = 0`, `PORT_DBG = 1`.
- **Sub-module `rr_arbiter2`:** 2-way round-robin arbiter with `req[1:0]`, `grant[1:0]` and an internal `last_grant` register.
- **Top level:** fault check, memory mux, response slots and counter.

## Test plan

- **Port 0 store then load.** Port 0 stores `0xDEADBEEF_CAFEF00D` at `0x40`, then loads `0x40`.
  - Required: `mem_write_en` high for 1 cycle with `mem_address = 0x40`.
  - Required: the load response one cycle after its accept carries the stored data, with fault 0.
- **Tie after reset.** Both ports issue valid loads in the first cycle after reset, with both `resp_ready` held at 1.
  - Required: grants are port 0, then port 1, then port 0.
  - Required: each response arrives exactly 1 cycle after its grant.
- **Misaligned and out-of-range.** Port 1 stores to `0x43`, then to `0x400`.
  - Required: each returns `resp_fault = 1` and `rdata = 0`.
  - Required: no memory enable is asserted, and `fault_count` goes 0 → 1 → 2.
- **Backpressure.** Hold `resp_ready[0] = 0` after one port 0 load, with port 0 still requesting.
  - Required: `req_ready[0]` stays 0 and port 1 requests are granted every cycle.
  - When `resp_ready[0]` rises: port 0 is granted in that same cycle.
- **Reset mid-stream.** Drop `rstn` in the cycle a port 0 store is valid.
  - Required: no write occurs, and all `resp_valid` bits read 0 after the edge.
  - Required: a later load of that address returns 0.
- **Fault counter saturation.** With `FCNT_W = 2`, issue 5 faulted requests.
  - Required: `fault_count` reads 3 and stays at 3.
